ni_packetizer: RTL and testbench

- Network-interface transmit stage that sits directly upstream of the router Local input port.
- Converts a PE-side command (destination, payload length) plus a stream of payload words into a header, body and tail flit sequence.
- Drives the router's L_RX/L_DRTS and obeys its L_CTS flow control.
- Generates even parity per flit and a wrapping packet ID.

---
 rtl/ni_packetizer.sv | 118 +++++++++++
 tb/tb_ni_packetizer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_packetizer.sv
// NI transmit stage: PE command + payload words -> header/body/tail flits toward router Local port.
// Latency: header registered one edge after the HDR cycle; payload then one flit per cycle.
// Backpressure: tx_cts gates every flit; data_ready follows tx_cts in PAYLOAD, commands only taken in IDLE.
module ni_packetizer #(
    parameter int DATA_WIDTH = 32,
    parameter int AXIS       = 4,
    parameter int MAX_LEN    = 4094
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AXIS-1:0]       cur_addr,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [AXIS-1:0]       cmd_dst,
    input  logic [11:0]           cmd_len,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic [27:0]           data_in,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_drts,
    input  logic                  tx_cts,
    output logic                  busy,
    output logic                  cmd_err,
    output logic [7:0]            pkt_id
);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    localparam logic [2:0]  TYPE_HDR  = 3'b001;
    localparam logic [2:0]  TYPE_BODY = 3'b010;
    localparam logic [2:0]  TYPE_TAIL = 3'b100;
    localparam logic [11:0] LEN_MAX   = 12'(MAX_LEN);

    state_t          state, state_nxt;
    logic [AXIS-1:0] dst_q, src_q;
    logic [11:0]     len_q, rem_q;
    logic            cmd_ok, cmd_bad, hdr_go, pay_go;
    logic [DATA_WIDTH-1:0] hdr_raw, pay_raw, hdr_flit, pay_flit;

    assign cmd_ready  = (state == IDLE);
    assign data_ready = (state == PAYLOAD) && tx_cts;
    assign busy       = (state != IDLE);

    // Parity bit is left at zero in the raw flit and filled from bits [31:1].
    assign hdr_raw  = {TYPE_HDR, len_q + 12'd1, dst_q, src_q, pkt_id, 1'b0};
    assign pay_raw  = {(rem_q == 12'd1) ? TYPE_TAIL : TYPE_BODY, data_in, 1'b0};
    assign hdr_flit = {hdr_raw[DATA_WIDTH-1:1], ^hdr_raw[DATA_WIDTH-1:1]};
    assign pay_flit = {pay_raw[DATA_WIDTH-1:1], ^pay_raw[DATA_WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ok    = 1'b0;
        cmd_bad   = 1'b0;
        hdr_go    = 1'b0;
        pay_go    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len != 12'd0 && cmd_len <= LEN_MAX) begin
                        cmd_ok    = 1'b1;
                        state_nxt = HDR;
                    end else begin
                        cmd_bad = 1'b1;
                    end
                end
            end
            HDR: begin
                if (tx_cts) begin
                    hdr_go    = 1'b1;
                    state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (data_valid && tx_cts) begin
                    pay_go = 1'b1;
                    if (rem_q == 12'd1) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_data <= '0;
            tx_drts <= 1'b0;
            cmd_err <= 1'b0;
            pkt_id  <= 8'd0;
            dst_q   <= '0;
            src_q   <= '0;
            len_q   <= 12'd0;
            rem_q   <= 12'd0;
        end else begin
            tx_drts <= hdr_go | pay_go;
            cmd_err <= cmd_bad;
            if (cmd_ok) begin
                dst_q  <= cmd_dst;
                src_q  <= cur_addr;
                len_q  <= cmd_len;
                pkt_id <= pkt_id + 8'd1;
            end
            if (hdr_go) begin
                tx_data <= hdr_flit;
                rem_q   <= len_q;
            end
            if (pay_go) begin
                tx_data <= pay_flit;
                rem_q   <= rem_q - 12'd1;
            end
        end
    end

endmodule

// File: tb/tb_ni_packetizer.sv
// Randomized bench for ni_packetizer; expected flit streams come from a packet-level model.
module tb_ni_packetizer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  cur_addr = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_dst = '0;
    logic [11:0] cmd_len = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [27:0] data_in = '0;
    logic [31:0] tx_data;
    logic        tx_drts;
    logic        tx_cts = 1'b1;
    logic        busy;
    logic        cmd_err;
    logic [7:0]  pkt_id;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_id = 0;

    logic [27:0] pay_q[$];
    logic [31:0] obs_q[$];
    int          obs_cyc[$];
    int          bad_drts, bad_ready;
    logic        busy_after;

    always #5 clk = ~clk;

    ni_packetizer #(.DATA_WIDTH(32), .AXIS(4), .MAX_LEN(4094)) dut (
        .clk(clk), .rst(rst), .cur_addr(cur_addr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
        .tx_data(tx_data), .tx_drts(tx_drts), .tx_cts(tx_cts),
        .busy(busy), .cmd_err(cmd_err), .pkt_id(pkt_id)
    );

    function automatic logic [31:0] with_par(input logic [31:0] f);
        int ones = 0;
        for (int i = 1; i < 32; i++) ones += int'(f[i]);
        f[0] = (ones % 2 == 1);
        return f;
    endfunction

    // Whole expected flit list of one packet, built from the command and its payload words.
    task automatic model_packet(input logic [3:0] dst, input int len, input logic [3:0] src,
                                input int id, output logic [31:0] exp_q[$]);
        logic [31:0] f;
        exp_q.delete();
        f = '0;
        f[31:29] = 3'b001;
        f[28:17] = 12'(len + 1);
        f[16:13] = dst;
        f[12:9]  = src;
        f[8:1]   = 8'(id);
        exp_q.push_back(with_par(f));
        for (int i = 0; i < len; i++) begin
            f = '0;
            f[31:29] = (i == len - 1) ? 3'b100 : 3'b010;
            f[28:1]  = pay_q[i];
            exp_q.push_back(with_par(f));
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cmd_valid = 1'b0;
        data_valid = 1'b0;
        tx_cts = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_id = 0;
        @(negedge clk);
    endtask

    // Drives one command and its payload; records emitted flits. mode 0: cts=1, 1: random, 2: 1,0,0,1.
    task automatic send_packet(input logic [3:0] dst, input int len, input logic [3:0] src,
                               input int mode, input int stop_after);
        int cyc = 0;
        int idx = 0;
        bit done = 0, hdr_seen = 0, cts_s, acc_cmd, acc_dat;
        bit [3:0] pat = 4'b1001;
        obs_q.delete();
        obs_cyc.delete();
        bad_drts = 0;
        bad_ready = 0;
        busy_after = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dst = dst;
        cmd_len = 12'(len);
        cur_addr = src;
        while (!done && cyc < 400) begin
            case (mode)
                0:       tx_cts = 1'b1;
                1:       tx_cts = ($urandom_range(0, 3) != 0);
                default: tx_cts = pat[3 - (cyc % 4)];
            endcase
            data_valid = (idx < len) && (mode != 1 || $urandom_range(0, 4) != 0);
            data_in = (idx < pay_q.size()) ? pay_q[idx] : 28'h0;
            #1;
            cts_s   = tx_cts;
            acc_cmd = cmd_valid && cmd_ready;
            acc_dat = data_valid && data_ready;
            if (data_ready && (!tx_cts || !hdr_seen)) bad_ready++;
            @(posedge clk);
            #1;
            if (acc_cmd) begin
                cmd_valid = 1'b0;
                exp_id = (exp_id + 1) % 256;
            end
            if (acc_dat) idx++;
            if (tx_drts) begin
                if (!cts_s) bad_drts++;
                obs_q.push_back(tx_data);
                obs_cyc.push_back(cyc);
                if (tx_data[31:29] == 3'b001) hdr_seen = 1;
                if (tx_data[31:29] == 3'b100) begin
                    done = 1;
                    busy_after = busy;
                end
                if (stop_after != 0 && obs_q.size() == stop_after) done = 1;
            end
            cyc++;
            @(negedge clk);
        end
        data_valid = 1'b0;
        tx_cts = 1'b1;
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL packet_timeout: got %0d flits after %0d cycles, needed a tail", obs_q.size(), cyc);
        end
    endtask

    task automatic fill_payload(input int len, input bit counting);
        pay_q.delete();
        for (int i = 0; i < len; i++)
            pay_q.push_back(counting ? 28'(i + 1) : 28'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        n_cmp += 7;
        if (tx_drts !== 1'b0)    begin n_fail++; $display("FAIL reset_drts: got %b need 0", tx_drts); end
        if (tx_data !== 32'h0)   begin n_fail++; $display("FAIL reset_data: got %h need 0", tx_data); end
        if (cmd_err !== 1'b0)    begin n_fail++; $display("FAIL reset_err: got %b need 0", cmd_err); end
        if (pkt_id !== 8'h0)     begin n_fail++; $display("FAIL reset_id: got %0d need 0", pkt_id); end
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy); end
        if (cmd_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_cmd_ready: got %b need 1", cmd_ready); end
        if (data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_data_ready: got %b need 0", data_ready); end
        do_reset();
    endtask

    task automatic check_stream(input string name, input logic [31:0] exp_q[$]);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d flits need %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s_flit%0d: got %h need %h", name, i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp += 3;
        if (bad_drts != 0)     begin n_fail++; $display("FAIL %s_drts_no_cts: got %0d need 0", name, bad_drts); end
        if (bad_ready != 0)    begin n_fail++; $display("FAIL %s_data_ready: got %0d bad cycles need 0", name, bad_ready); end
        if (busy_after !== 1'b0) begin n_fail++; $display("FAIL %s_busy_after_tail: got %b need 0", name, busy_after); end
    endtask

    task automatic test_basic();
        logic [31:0] exp_q[$];
        fill_payload(3, 1'b1);
        send_packet(4'h3, 3, 4'h0, 0, 0);
        model_packet(4'h3, 3, 4'h0, 1, exp_q);
        check_stream("basic", exp_q);
        n_cmp++;
        if (obs_cyc.size() == 4 && obs_cyc[3] - obs_cyc[0] != 3) begin
            n_fail++;
            $display("FAIL basic_consecutive: got span %0d need 3", obs_cyc[3] - obs_cyc[0]);
        end
    endtask

    task automatic test_len1();
        logic [31:0] exp_q[$];
        fill_payload(1, 1'b0);
        send_packet(4'h5, 1, 4'h2, 0, 0);
        model_packet(4'h5, 1, 4'h2, exp_id, exp_q);
        check_stream("len1", exp_q);
    endtask

    task automatic test_cts_toggle();
        logic [31:0] exp_q[$];
        fill_payload(4, 1'b0);
        send_packet(4'ha, 4, 4'h7, 2, 0);
        model_packet(4'ha, 4, 4'h7, exp_id, exp_q);
        check_stream("cts_toggle", exp_q);
    endtask

    task automatic test_len_reject();
        logic [11:0] bad_len[2] = '{12'd0, 12'd4095};
        logic [7:0]  id0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            id0 = pkt_id;
            cmd_valid = 1'b1;
            cmd_len = bad_len[k];
            cmd_dst = 4'h9;
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            n_cmp += 4;
            if (cmd_err !== 1'b1) begin n_fail++; $display("FAIL reject%0d_err: got %b need 1", k, cmd_err); end
            if (busy !== 1'b0)    begin n_fail++; $display("FAIL reject%0d_busy: got %b need 0", k, busy); end
            if (tx_drts !== 1'b0) begin n_fail++; $display("FAIL reject%0d_drts: got %b need 0", k, tx_drts); end
            if (pkt_id !== id0)   begin n_fail++; $display("FAIL reject%0d_id: got %0d need %0d", k, pkt_id, id0); end
            @(posedge clk);
            #1;
            n_cmp += 2;
            if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL reject%0d_err_pulse: got %b need 0", k, cmd_err); end
            if (tx_drts !== 1'b0) begin n_fail++; $display("FAIL reject%0d_drts2: got %b need 0", k, tx_drts); end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_q[$];
        logic [3:0]  d, s;
        int          len;
        for (int p = 0; p < 8; p++) begin
            d = 4'($urandom);
            s = 4'($urandom);
            len = $urandom_range(1, 6);
            fill_payload(len, 1'b0);
            send_packet(d, len, s, 1, 0);
            model_packet(d, len, s, exp_id, exp_q);
            check_stream("random", exp_q);
        end
    endtask

    task automatic test_back_to_back_wrap();
        logic [31:0] exp_q[$];
        do_reset();
        for (int p = 0; p < 256; p++) begin
            fill_payload(1, 1'b0);
            send_packet(4'h1, 1, 4'h4, 0, 0);
            model_packet(4'h1, 1, 4'h4, exp_id, exp_q);
            n_cmp += 2;
            if (pkt_id !== 8'(exp_id)) begin
                n_fail++;
                $display("FAIL wrap_pkt_id%0d: got %0d need %0d", p, pkt_id, exp_id);
            end
            if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
                n_fail++;
                $display("FAIL wrap_flits%0d: got %0d flits hdr %h need hdr %h", p, obs_q.size(),
                         (obs_q.size() > 0) ? obs_q[0] : 32'h0, exp_q[0]);
            end
        end
        n_cmp++;
        if (exp_id != 0 || pkt_id !== 8'h0) begin
            n_fail++;
            $display("FAIL wrap_final_id: got %0d need 0", pkt_id);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_q[$];
        fill_payload(8, 1'b0);
        send_packet(4'h6, 8, 4'h1, 0, 3);
        #2;
        rst = 1'b0;
        #1;
        n_cmp += 3;
        if (tx_drts !== 1'b0) begin n_fail++; $display("FAIL midrst_drts: got %b need 0", tx_drts); end
        if (busy !== 1'b0)    begin n_fail++; $display("FAIL midrst_busy: got %b need 0", busy); end
        if (pkt_id !== 8'h0)  begin n_fail++; $display("FAIL midrst_id: got %0d need 0", pkt_id); end
        exp_id = 0;
        @(negedge clk);
        rst = 1'b1;
        fill_payload(2, 1'b0);
        send_packet(4'hc, 2, 4'h3, 0, 0);
        model_packet(4'hc, 2, 4'h3, 1, exp_q);
        check_stream("after_rst", exp_q);
        n_cmp++;
        if (pkt_id !== 8'h1) begin n_fail++; $display("FAIL after_rst_id: got %0d need 1", pkt_id); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len1();
        test_cts_toggle();
        test_len_reject();
        test_random();
        test_back_to_back_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
